mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port, fixed-latency unified memory between two requesters: the instruction-fetch port and the load/store data port of the cpu datapath.
- Sits between the datapath and the memory model.
- Serialises accesses under a req/done handshake and drives a stall line that freezes PC and pipeline state while any access is outstanding.
- Tie-break between simultaneous requests is either fixed (data first) or round-robin.

Parameters:
- ADDR_W, 32, address width of both ports and memory.
- DATA_W, 32, data width.
- MEM_LAT, 2, memory read latency in cycles (>=1); also the fixed occupancy of a write.
- PRIO_MODE, 0, tie-break mode: 0 = data always wins; 1 = round-robin, where the port granted last loses the tie.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request, held until if_done.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched word, registered, valid while if_done=1.
- if_done  out  1  one-cycle completion pulse for fetch.
- d_req  in  1  data request, held until d_done.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data, registered, valid while d_done=1.
- d_done  out  1  one-cycle completion pulse for data.
- d_err  out  1  misaligned access flag, valid with d_done.
- mem_en  out  1  one-cycle memory strobe.
- mem_we  out  1  write enable, valid with mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid exactly MEM_LAT cycles after the mem_en cycle.
- stall  out  1  combinational: (if_req & ~if_done) | (d_req & ~d_done).

Behaviour:
- Reset (async, immediate): state=IDLE, cnt=0, last_grant=FETCH.
  - All registered outputs go to 0: if_rdata, d_rdata, if_done, d_done, d_err, mem_en, mem_we, mem_addr, mem_wdata.
  - stall is not registered; it follows the inputs.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, cycle T, any req high:
  - Grant by PRIO_MODE.
  - Latch owner, address, we and wdata.
  - Go to ACCESS, load cnt=MEM_LAT.
  - Exception: a data grant with d_addr[1:0]!=0 goes straight to DONE with err set; no mem_en is issued.
- ACCESS, first cycle (T+1): mem_en=1 for exactly this cycle, mem_we=latched we.
  - mem_addr and mem_wdata hold the latched values for the whole access.
- ACCESS countdown: cnt decrements each cycle.
  - In the cycle cnt==0 (T+1+MEM_LAT), mem_rdata is captured into the owner's rdata register. Loads only; stores leave rdata unchanged.
  - Next state is DONE.
- DONE (T+2+MEM_LAT for a normal access): owner's done=1 for one cycle, d_err=err for data accesses, last_grant=owner, next state IDLE.
  - Requests are ignored in DONE.
  - A requester keeping req high after done is treated as a new request, sampled in the following IDLE cycle.
- Latency: request sampled at T gives done at T+MEM_LAT+2 (T+4 at the default). A misaligned access gives done at T+1.
- Throughput: one access per MEM_LAT+3 cycles. Back-to-back requests have one IDLE cycle between them.
- Non-owner request: stays pending with stall=1 and is served on the next IDLE.
- A latched request whose req drops mid-access still completes and still pulses done.
- Address and data inputs that change during an access are ignored.
- done pulses for the two ports are never simultaneous.
- Reset mid-access: the access is abandoned and no done is issued. A req still held after reset is served from scratch.

Decomposition:
- Package mem_arb_pkg holds:
  - the state encoding (IDLE/ACCESS/DONE);
  - owner constants OWN_FETCH=0, OWN_DATA=1;
  - PRIO constants PRIO_FIXED=0, PRIO_RR=1.
- One sub-module, arb_prio2: combinational 2-way grant from (if_req, d_req, last_grant, PRIO_MODE).
- Everything else lives in mem_arbiter.

Test Plan:
- Fetch only, MEM_LAT=2: if_req=1 with if_addr=0x40 at T; memory returns 0x8C010004.
  - Expect mem_en=1, mem_we=0, mem_addr=0x40 at T+1 only.
  - Expect if_done=1 and if_rdata=0x8C010004 at T+4.
  - Expect stall=1 over T..T+3 and 0 at T+4.
- Conflict, PRIO_MODE=0: d_req store with addr 0x100, wdata 0xDEADBEEF, and if_req with addr 0x44, both at T.
  - Expect mem_we=1, addr 0x100 at T+1 and d_done at T+4.
  - Expect fetch mem_en at T+6 and if_done at T+9.
  - d_rdata is unchanged.
- Conflict, PRIO_MODE=1: both ports request continuously.
  - Expect grants alternating fetch, data, fetch.
  - No port waits more than one access.
- Misaligned load d_addr=0x102 at T: expect no mem_en, d_done=1 and d_err=1 at T+1.
- rst pulse at T+2 during a fetch: outputs immediately 0 and no if_done. After release with if_req still high, a full fresh access completes at release+4.
- if_req dropped at T+2 mid-access: if_done still pulses at T+4, and the next IDLE grants nothing.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared constants for the two-port memory arbiter: FSM encoding, owner ids, tie-break modes.
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  localparam int unsigned PRIO_FIXED = 0;
  localparam int unsigned PRIO_RR    = 1;

  // A data access must be word aligned; anything else is rejected without touching memory.
  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/arb_prio2.sv
// Combinational two-way grant between the fetch and data ports.
module arb_prio2
  import mem_arb_pkg::*;
#(
  parameter int unsigned PRIO_MODE = PRIO_FIXED
) (
  input  logic i_if_req,
  input  logic i_d_req,
  input  logic i_last_grant,
  output logic o_grant_c,
  output logic o_owner_c
);

  // Grant any request; on a tie either data wins or the last winner yields.
  always_comb begin
    o_grant_c = i_if_req | i_d_req;
    o_owner_c = OWN_FETCH;
    if (i_if_req && i_d_req) begin
      if (PRIO_MODE == PRIO_RR) begin
        o_owner_c = (i_last_grant == OWN_FETCH) ? OWN_DATA : OWN_FETCH;
      end else begin
        o_owner_c = OWN_DATA;
      end
    end else if (i_d_req) begin
      o_owner_c = OWN_DATA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises fetch and load/store accesses onto one fixed-latency memory port.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_LAT   = 2,
  parameter int unsigned PRIO_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              d_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);

  logic [1:0]        r_state,     w_state_nxt;
  logic [CNT_W-1:0]  r_cnt,       w_cnt_nxt;
  logic              r_owner,     w_owner_nxt;
  logic              r_we,        w_we_nxt;
  logic              r_last,      w_last_nxt;
  logic [ADDR_W-1:0] r_mem_addr,  w_mem_addr_nxt;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic [DATA_W-1:0] r_if_rdata,  w_if_rdata_nxt;
  logic [DATA_W-1:0] r_d_rdata,   w_d_rdata_nxt;
  logic              r_if_done,   w_if_done_nxt;
  logic              r_d_done,    w_d_done_nxt;
  logic              r_d_err,     w_d_err_nxt;
  logic              r_mem_en,    w_mem_en_nxt;
  logic              r_mem_we,    w_mem_we_nxt;
  logic              w_grant;
  logic              w_owner;

  arb_prio2 #(
    .PRIO_MODE(PRIO_MODE)
  ) u_arb (
    .i_if_req    (if_req),
    .i_d_req     (d_req),
    .i_last_grant(r_last),
    .o_grant_c   (w_grant),
    .o_owner_c   (w_owner)
  );

  // Next-state and next-output logic for the IDLE -> ACCESS -> DONE sequence.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_owner_nxt     = r_owner;
    w_we_nxt        = r_we;
    w_last_nxt      = r_last;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_if_rdata_nxt  = r_if_rdata;
    w_d_rdata_nxt   = r_d_rdata;
    w_if_done_nxt   = 1'b0;
    w_d_done_nxt    = 1'b0;
    w_d_err_nxt     = 1'b0;
    w_mem_en_nxt    = 1'b0;
    w_mem_we_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant) begin
          w_owner_nxt = w_owner;
          if (w_owner == OWN_DATA && is_misaligned(d_addr[1:0])) begin
            // Rejected before the memory sees it: done and err next cycle.
            w_we_nxt     = d_we;
            w_state_nxt  = ST_DONE;
            w_d_done_nxt = 1'b1;
            w_d_err_nxt  = 1'b1;
          end else begin
            w_state_nxt  = ST_ACCESS;
            w_cnt_nxt    = CNT_W'(MEM_LAT);
            w_mem_en_nxt = 1'b1;
            if (w_owner == OWN_DATA) begin
              w_we_nxt        = d_we;
              w_mem_we_nxt    = d_we;
              w_mem_addr_nxt  = d_addr;
              w_mem_wdata_nxt = d_wdata;
            end else begin
              w_we_nxt       = 1'b0;
              w_mem_addr_nxt = if_addr;
            end
          end
        end
      end
      ST_ACCESS: begin
        if (r_cnt == '0) begin
          // Read data is on mem_rdata exactly now; stores leave rdata alone.
          w_state_nxt = ST_DONE;
          if (r_owner == OWN_DATA) begin
            w_d_done_nxt = 1'b1;
            if (!r_we) begin
              w_d_rdata_nxt = mem_rdata;
            end
          end else begin
            w_if_done_nxt  = 1'b1;
            w_if_rdata_nxt = mem_rdata;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_DONE: begin
        w_last_nxt  = r_owner;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_owner     <= OWN_FETCH;
      r_we        <= 1'b0;
      r_last      <= OWN_FETCH;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_if_done   <= 1'b0;
      r_d_done    <= 1'b0;
      r_d_err     <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_owner     <= w_owner_nxt;
      r_we        <= w_we_nxt;
      r_last      <= w_last_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_if_rdata  <= w_if_rdata_nxt;
      r_d_rdata   <= w_d_rdata_nxt;
      r_if_done   <= w_if_done_nxt;
      r_d_done    <= w_d_done_nxt;
      r_d_err     <= w_d_err_nxt;
      r_mem_en    <= w_mem_en_nxt;
      r_mem_we    <= w_mem_we_nxt;
    end
  end

  assign if_rdata  = r_if_rdata;
  assign if_done   = r_if_done;
  assign d_rdata   = r_d_rdata;
  assign d_done    = r_d_done;
  assign d_err     = r_d_err;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  // Freeze the pipeline while any request is still waiting for its done.
  assign stall = (if_req & ~r_if_done) | (d_req & ~r_d_done);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench: instance 0 uses fixed priority, instance 1 round-robin.
module tb_mem_arbiter;

  localparam int unsigned LAT = 2;
  localparam logic [31:0] GARBAGE = 32'hBAD0BAD0;

  localparam int K_STALL = 0, K_MEM_EN = 1, K_MEM_ADDR = 2, K_MEM_WDATA = 3,
                 K_IF_DONE = 4, K_D_DONE = 5, K_IF_RDATA = 6, K_D_RDATA = 7;

  typedef struct { int cyc; int port; logic [31:0] rdata; logic err; } done_t;
  typedef struct { int cyc; logic we; logic [31:0] addr; logic [31:0] wdata; } strobe_t;
  typedef struct { int cyc; int kind; logic [31:0] val; } level_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req    [2];
  logic [31:0] if_addr   [2];
  logic [31:0] if_rdata  [2];
  logic        if_done   [2];
  logic        d_req     [2];
  logic        d_we      [2];
  logic [31:0] d_addr    [2];
  logic [31:0] d_wdata   [2];
  logic [31:0] d_rdata   [2];
  logic        d_done    [2];
  logic        d_err     [2];
  logic        mem_en    [2];
  logic        mem_we    [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  logic        stall     [2];

  done_t   done_q [2][$];
  strobe_t mem_q  [2][$];
  level_t  lv_q   [2][$];

  logic        dl_v [2][LAT+1];
  logic [31:0] dl_d [2][LAT+1];
  logic [31:0] mem_img [logic [32:0]];

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  logic end_chk = 1'b0;
  logic end_done = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_arbiter #(
      .ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .PRIO_MODE(g)
    ) u_dut (
      .clk(clk), .rst(rst),
      .if_req(if_req[g]), .if_addr(if_addr[g]), .if_rdata(if_rdata[g]), .if_done(if_done[g]),
      .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
      .d_rdata(d_rdata[g]), .d_done(d_done[g]), .d_err(d_err[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]), .stall(stall[g])
    );
  end

  task automatic chk(input int i, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL inst%0d %s: got 0x%08h required 0x%08h (cycle %0d)", i, name, act, exp, cyc);
    end
  endtask

  task automatic report(input int i, input string name, input string what);
    checks++;
    errors++;
    $display("FAIL inst%0d %s: %s (cycle %0d)", i, name, what, cyc);
  endtask

  function automatic string kname(input int k);
    case (k)
      K_STALL:     return "stall";
      K_MEM_EN:    return "mem_en";
      K_MEM_ADDR:  return "mem_addr";
      K_MEM_WDATA: return "mem_wdata";
      K_IF_DONE:   return "if_done";
      K_D_DONE:    return "d_done";
      K_IF_RDATA:  return "if_rdata";
      default:     return "d_rdata";
    endcase
  endfunction

  function automatic logic [31:0] get_sig(input int i, input int k);
    case (k)
      K_STALL:     return {31'b0, stall[i]};
      K_MEM_EN:    return {31'b0, mem_en[i]};
      K_MEM_ADDR:  return mem_addr[i];
      K_MEM_WDATA: return mem_wdata[i];
      K_IF_DONE:   return {31'b0, if_done[i]};
      K_D_DONE:    return {31'b0, d_done[i]};
      K_IF_RDATA:  return if_rdata[i];
      default:     return d_rdata[i];
    endcase
  endfunction

  // Unwritten words read as a fixed pattern anchored at 0x40 -> 0x8C010004.
  function automatic logic [31:0] rd_model(input int i, input logic [31:0] a);
    logic [32:0] key;
    key = {1'(i), a};
    if (mem_img.exists(key)) return mem_img[key];
    return 32'h8C010004 + (a - 32'h40);
  endfunction

  // Monitor and memory model, both on the falling edge.
  always @(negedge clk) begin
    done_t   e;
    strobe_t s;
    logic    fired;
    for (int i = 0; i < 2; i++) begin
      for (int k = lv_q[i].size() - 1; k >= 0; k--) begin
        if (lv_q[i][k].cyc <= cyc) begin
          chk(i, kname(lv_q[i][k].kind), get_sig(i, lv_q[i][k].kind), lv_q[i][k].val);
          lv_q[i].delete(k);
        end
      end
      if (if_done[i] || d_done[i]) chk(i, "one done at a time", {31'b0, if_done[i] & d_done[i]}, 32'h0);
      for (int p = 0; p < 2; p++) begin
        fired = (p == 0) ? if_done[i] : d_done[i];
        if (fired) begin
          if (done_q[i].size() == 0) begin
            report(i, (p == 0) ? "if_done" : "d_done", "pulse with none required");
          end else begin
            e = done_q[i].pop_front();
            chk(i, "done port", 32'(p), 32'(e.port));
            chk(i, "done cycle", 32'(cyc), 32'(e.cyc));
            chk(i, (p == 0) ? "if_rdata" : "d_rdata", (p == 0) ? if_rdata[i] : d_rdata[i], e.rdata);
            if (p == 1) chk(i, "d_err", {31'b0, d_err[i]}, {31'b0, e.err});
          end
        end
      end
      if (done_q[i].size() > 0 && done_q[i][0].cyc < cyc) begin
        e = done_q[i].pop_front();
        report(i, "done", $sformatf("missing, required at cycle %0d", e.cyc));
      end
      if (mem_en[i]) begin
        if (mem_q[i].size() == 0) begin
          report(i, "mem_en", "strobe with none required");
        end else begin
          s = mem_q[i].pop_front();
          chk(i, "mem_en cycle", 32'(cyc), 32'(s.cyc));
          chk(i, "mem_we", {31'b0, mem_we[i]}, {31'b0, s.we});
          chk(i, "strobe addr", mem_addr[i], s.addr);
          if (s.we) chk(i, "strobe wdata", mem_wdata[i], s.wdata);
        end
      end
      if (mem_q[i].size() > 0 && mem_q[i][0].cyc < cyc) begin
        s = mem_q[i].pop_front();
        report(i, "mem_en", $sformatf("missing, required at cycle %0d", s.cyc));
      end
      if (end_chk && !end_done) begin
        chk(i, "pending done", 32'(done_q[i].size()), 32'h0);
        chk(i, "pending strobe", 32'(mem_q[i].size()), 32'h0);
      end
      if (rst) begin
        for (int k = 0; k <= LAT; k++) dl_v[i][k] = 1'b0;
        mem_rdata[i] = GARBAGE;
      end else begin
        if (mem_en[i] && mem_we[i]) mem_img[{1'(i), mem_addr[i]}] = mem_wdata[i];
        for (int k = LAT; k > 0; k--) begin
          dl_v[i][k] = dl_v[i][k-1];
          dl_d[i][k] = dl_d[i][k-1];
        end
        dl_v[i][0] = mem_en[i] && !mem_we[i];
        dl_d[i][0] = rd_model(i, mem_addr[i]);
        mem_rdata[i] = dl_v[i][LAT] ? dl_d[i][LAT] : GARBAGE;
      end
    end
    if (end_chk) end_done = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_done(input int i, input int c, input int port, input logic [31:0] rd, input logic err);
    done_t e;
    e.cyc = c; e.port = port; e.rdata = rd; e.err = err;
    done_q[i].push_back(e);
  endtask

  task automatic exp_mem(input int i, input int c, input logic we, input logic [31:0] a, input logic [31:0] wd);
    strobe_t s;
    s.cyc = c; s.we = we; s.addr = a; s.wdata = wd;
    mem_q[i].push_back(s);
  endtask

  task automatic exp_lv(input int i, input int c, input int k, input logic [31:0] v);
    level_t l;
    l.cyc = c; l.kind = k; l.val = v;
    lv_q[i].push_back(l);
  endtask

  initial begin
    int t;
    int r;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if_req[i] = 1'b0; if_addr[i] = '0; d_req[i] = 1'b0; d_we[i] = 1'b0;
      d_addr[i] = '0; d_wdata[i] = '0; mem_rdata[i] = GARBAGE;
    end
    tick(); tick();
    for (int i = 0; i < 2; i++)
      for (int k = K_STALL; k <= K_D_RDATA; k++) exp_lv(i, cyc, k, 32'h0);
    tick(); rst = 1'b0; tick();

    // Fetch only.
    t = cyc; if_addr[0] = 32'h40; if_req[0] = 1'b1;
    exp_mem(0, t+1, 1'b0, 32'h40, 32'h0);
    exp_done(0, t+4, 0, 32'h8C010004, 1'b0);
    for (int k = 0; k < 4; k++) exp_lv(0, t+k, K_STALL, 32'h1);
    exp_lv(0, t+4, K_STALL, 32'h0);
    exp_lv(0, t+2, K_MEM_EN, 32'h0);
    repeat (5) tick(); if_req[0] = 1'b0; tick();

    // Simultaneous store and fetch, data first; inputs change mid-access.
    t = cyc;
    d_we[0] = 1'b1; d_addr[0] = 32'h100; d_wdata[0] = 32'hDEADBEEF; d_req[0] = 1'b1;
    if_addr[0] = 32'h44; if_req[0] = 1'b1;
    exp_mem(0, t+1, 1'b1, 32'h100, 32'hDEADBEEF);
    exp_done(0, t+4, 1, 32'h0, 1'b0);
    exp_mem(0, t+6, 1'b0, 32'h44, 32'h0);
    exp_done(0, t+9, 0, 32'h8C010008, 1'b0);
    exp_lv(0, t+3, K_MEM_ADDR, 32'h100);
    exp_lv(0, t+3, K_MEM_WDATA, 32'hDEADBEEF);
    exp_lv(0, t+5, K_STALL, 32'h1);
    exp_lv(0, t+9, K_STALL, 32'h0);
    repeat (2) tick(); d_addr[0] = 32'h200; d_wdata[0] = 32'h12345678;
    repeat (2) tick(); d_req[0] = 1'b0; d_we[0] = 1'b0;
    repeat (6) tick(); if_req[0] = 1'b0; tick();

    // Load back the stored word.
    t = cyc; d_addr[0] = 32'h100; d_req[0] = 1'b1;
    exp_mem(0, t+1, 1'b0, 32'h100, 32'h0);
    exp_done(0, t+4, 1, 32'hDEADBEEF, 1'b0);
    repeat (4) tick(); d_req[0] = 1'b0; tick();

    // Misaligned load: no strobe, done and err next cycle, rdata kept.
    t = cyc; d_addr[0] = 32'h102; d_req[0] = 1'b1;
    exp_done(0, t+1, 1, 32'hDEADBEEF, 1'b1);
    exp_lv(0, t, K_STALL, 32'h1);
    exp_lv(0, t+1, K_MEM_EN, 32'h0);
    tick(); d_req[0] = 1'b0; tick();

    // Aligned load afterwards clears err.
    t = cyc; d_addr[0] = 32'h104; d_req[0] = 1'b1;
    exp_mem(0, t+1, 1'b0, 32'h104, 32'h0);
    exp_done(0, t+4, 1, 32'h8C0100C8, 1'b0);
    repeat (4) tick(); d_req[0] = 1'b0; tick();

    // Reset in the middle of a fetch; held request restarts from scratch.
    t = cyc; if_addr[0] = 32'h80; if_req[0] = 1'b1;
    exp_mem(0, t+1, 1'b0, 32'h80, 32'h0);
    exp_lv(0, t+1, K_MEM_ADDR, 32'h80);
    repeat (2) tick(); rst = 1'b1;
    exp_lv(0, t+2, K_MEM_ADDR, 32'h0);
    exp_lv(0, t+2, K_IF_RDATA, 32'h0);
    exp_lv(0, t+2, K_D_RDATA, 32'h0);
    exp_lv(0, t+2, K_STALL, 32'h1);
    tick(); rst = 1'b0; r = cyc;
    exp_mem(0, r+1, 1'b0, 32'h80, 32'h0);
    exp_done(0, r+4, 0, 32'h8C010044, 1'b0);
    repeat (5) tick(); if_req[0] = 1'b0; tick();

    // Request dropped mid-access still completes; nothing granted after.
    t = cyc; if_addr[0] = 32'h48; if_req[0] = 1'b1;
    exp_mem(0, t+1, 1'b0, 32'h48, 32'h0);
    exp_done(0, t+4, 0, 32'h8C01000C, 1'b0);
    exp_lv(0, t+2, K_STALL, 32'h0);
    exp_lv(0, t+6, K_MEM_EN, 32'h0);
    repeat (2) tick(); if_req[0] = 1'b0;
    repeat (7) tick();

    // Round-robin with both ports requesting continuously.
    t = cyc; if_addr[1] = 32'h40; if_req[1] = 1'b1;
    exp_mem(1, t+1, 1'b0, 32'h40, 32'h0);
    exp_done(1, t+4, 0, 32'h8C010004, 1'b0);
    exp_mem(1, t+6, 1'b0, 32'h104, 32'h0);
    exp_done(1, t+9, 1, 32'h8C0100C8, 1'b0);
    exp_mem(1, t+11, 1'b0, 32'h40, 32'h0);
    exp_done(1, t+14, 0, 32'h8C010004, 1'b0);
    exp_mem(1, t+16, 1'b0, 32'h104, 32'h0);
    exp_done(1, t+19, 1, 32'h8C0100C8, 1'b0);
    exp_lv(1, t+10, K_STALL, 32'h1);
    tick(); d_addr[1] = 32'h104; d_we[1] = 1'b0; d_req[1] = 1'b1;
    repeat (13) tick(); if_req[1] = 1'b0;
    repeat (5) tick(); d_req[1] = 1'b0;
    repeat (4) tick();

    end_chk = 1'b1;
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
